// File: rtl/scope_trace_sequencer.sv
// scope_trace_sequencer: triggered ADC capture into a double-buffered trace
// memory, with tear-free bank swaps at frame boundaries and a pixel renderer
// that draws the displayed trace over a graticule for the VGA timing block.
module scope_trace_sequencer #(
    parameter int          H_VISIBLE   = 640,
    parameter int          V_VISIBLE   = 480,
    parameter int          H_TOTAL     = 800,
    parameter int          Y_TOP       = 112,
    parameter int          DECIM       = 1,
    parameter int          AUTO_FRAMES = 8,
    parameter logic [3:0]  TRACE_LEVEL = 4'hF,
    parameter logic [3:0]  GRID_LEVEL  = 4'h4
) (
    input  logic        clk_25,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    input  logic [7:0]  trig_level,
    input  logic        run,
    input  logic [9:0]  h_counter,
    input  logic [11:0] v_counter,
    output logic [3:0]  data_out,
    output logic [1:0]  state,
    output logic        triggered,
    output logic        display_valid,
    output logic        disp_bank
);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [7:0]  DEC_LAST   = 8'(DECIM - 1);
    localparam logic [7:0]  AUTO_LIM   = 8'(AUTO_FRAMES);
    localparam logic [9:0]  LAST_ADDR  = 10'(H_VISIBLE - 1);
    localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
    localparam logic [11:0] V_LAST     = 12'(V_VISIBLE - 1);
    localparam logic [11:0] ROW_BASE   = 12'(Y_TOP + 255);

    state_t      cur_state;
    state_t      next_state;
    logic [7:0]  dec_cnt;
    logic [7:0]  prev_sample;
    logic [7:0]  auto_cnt;
    logic [9:0]  write_addr;
    logic        swap_pending;

    logic        frame_edge;
    logic        accepted;
    logic        crossing;
    logic        fire;
    logic        mem_we;
    logic [9:0]  mem_wa;
    logic        do_swap;

    logic [7:0]  bank0 [0:H_VISIBLE-1];
    logic [7:0]  bank1 [0:H_VISIBLE-1];
    logic [9:0]  read_addr;
    logic [9:0]  read_idx;
    logic [7:0]  rd_sample;
    logic [11:0] trace_row;
    logic        visible;
    logic        on_grid;

    assign frame_edge = (v_counter == V_VIS) && (h_counter == 10'd0);
    assign accepted   = sample_valid && (dec_cnt == 8'd0);
    assign crossing   = (prev_sample < trig_level) && (sample_data >= trig_level);
    assign state      = cur_state;

    // Next-state logic plus the write/trigger/swap strobes that go with each transition
    always_comb begin
        next_state = cur_state;
        fire       = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = write_addr;
        do_swap    = 1'b0;
        case (cur_state)
            ARM: begin
                next_state = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (accepted && (crossing || (auto_cnt >= AUTO_LIM))) begin
                    fire       = 1'b1;
                    mem_we     = 1'b1;
                    mem_wa     = 10'd0;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (accepted) begin
                    mem_we = 1'b1;
                    if (write_addr == LAST_ADDR) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_edge) begin
                    do_swap = swap_pending;
                    if (run) begin
                        next_state = ARM;
                    end
                end
            end
            default: begin
                next_state = ARM;
            end
        endcase
    end

    // State register, decimation, trigger history, auto-trigger timer and bank bookkeeping
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            cur_state     <= ARM;
            disp_bank     <= 1'b0;
            display_valid <= 1'b0;
            triggered     <= 1'b0;
            dec_cnt       <= 8'd0;
            auto_cnt      <= 8'd0;
            prev_sample   <= 8'd0;
            write_addr    <= 10'd0;
            swap_pending  <= 1'b0;
        end else begin
            cur_state <= next_state;
            triggered <= fire;
            if (sample_valid) begin
                dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
            end
            if (accepted) begin
                prev_sample <= sample_data;
            end
            if (cur_state == ARM) begin
                auto_cnt <= 8'd0;
            end else if ((cur_state == WAIT_TRIG) && frame_edge && (auto_cnt < AUTO_LIM)) begin
                auto_cnt <= auto_cnt + 8'd1;
            end
            if (fire) begin
                write_addr <= 10'd1;
            end else if ((cur_state == CAPTURE) && accepted) begin
                write_addr <= write_addr + 10'd1;
            end
            if ((cur_state == CAPTURE) && (next_state == DONE)) begin
                swap_pending <= 1'b1;
            end else if (do_swap) begin
                swap_pending <= 1'b0;
            end
            if (do_swap) begin
                disp_bank     <= ~disp_bank;
                display_valid <= 1'b1;
            end
        end
    end

    // Capture writes always land in the bank that is not on screen
    always_ff @(posedge clk_25) begin
        if (mem_we) begin
            if (disp_bank) begin
                bank0[mem_wa] <= sample_data;
            end else begin
                bank1[mem_wa] <= sample_data;
            end
        end
    end

    assign read_addr = (h_counter == H_LAST) ? 10'd0 : h_counter + 10'd1;
    assign read_idx  = (read_addr < H_VIS) ? read_addr : 10'd0;

    // Fetch one column ahead so the sample is ready when its column is drawn
    always_ff @(posedge clk_25) begin
        rd_sample <= disp_bank ? bank1[read_idx] : bank0[read_idx];
    end

    assign trace_row = ROW_BASE - {4'd0, rd_sample};
    assign visible   = (h_counter < H_VIS) && (v_counter < V_VIS);
    assign on_grid   = (h_counter[5:0] == 6'd0) || ((v_counter % 12'd48) == 12'd0) ||
                       (h_counter == LAST_ADDR) || (v_counter == V_LAST);

    // Pixel priority: blanking, then trace, then graticule
    always_comb begin
        data_out = 4'd0;
        if (!visible) begin
            data_out = 4'd0;
        end else if (display_valid && (v_counter == trace_row)) begin
            data_out = TRACE_LEVEL;
        end else if (on_grid) begin
            data_out = GRID_LEVEL;
        end
    end

endmodule

// File: tb/tb_scope_trace_sequencer.sv
// Self-checking bench for scope_trace_sequencer: drives ADC ramps/constants and
// hand-placed VGA counter positions, checks FSM status and rendered pixels.
module tb_scope_trace_sequencer;

    logic        clk_25 = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic [7:0]  trig_level;
    logic        run;
    logic [9:0]  h_counter;
    logic [11:0] v_counter;

    logic [3:0]  data_out,  data_out3;
    logic [1:0]  state,     state3;
    logic        triggered, triggered3;
    logic        display_valid, display_valid3;
    logic        disp_bank, disp_bank3;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    scope_trace_sequencer dut (
        .clk_25(clk_25), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_data(sample_data), .trig_level(trig_level), .run(run),
        .h_counter(h_counter), .v_counter(v_counter), .data_out(data_out),
        .state(state), .triggered(triggered), .display_valid(display_valid),
        .disp_bank(disp_bank)
    );

    scope_trace_sequencer #(.DECIM(3)) dut3 (
        .clk_25(clk_25), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_data(sample_data), .trig_level(trig_level), .run(run),
        .h_counter(h_counter), .v_counter(v_counter), .data_out(data_out3),
        .state(state3), .triggered(triggered3), .display_valid(display_valid3),
        .disp_bank(disp_bank3)
    );

    always #20 clk_25 = ~clk_25;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk_25);
    endtask

    task automatic frame();
        h_counter = 10'd0;
        v_counter = 12'd480;
        step();
        h_counter = 10'd700;
        v_counter = 12'd10;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    function automatic int grid_pix(input int x, input int y);
        if (x >= 640 || y >= 480) return 0;
        if (x % 64 == 0 || y % 48 == 0 || x == 639 || y == 479) return 4;
        return 0;
    endfunction

    function automatic int pix(input int x, input int y, input bit valid, input int s);
        if (x < 640 && y < 480 && valid && y == 367 - s) return 15;
        return grid_pix(x, y);
    endfunction

    // Scoreboard render: expected pixel queued when counters are driven, popped on output
    task automatic applyStimulus(input bit sel, input int x, input int y, input int expected);
        int got;
        h_counter = (x == 0) ? 10'd799 : 10'(x - 1);
        v_counter = 12'(y);
        exp_q.push_back(expected);
        step();
        h_counter = 10'(x);
        #1;
        got = sel ? int'(data_out3) : int'(data_out);
        checkOutput($sformatf("pix%0d_%0d_x%0d_y%0d", sel ? 3 : 1, checks, x, y), got, exp_q.pop_front());
        h_counter = 10'd700;
        v_counter = 12'd10;
    endtask

    task automatic feed_ramp(input int n, input int gap, input int trig_at, input int stop_at, input bit sel);
        int tr, st;
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = 8'(i);
            step();
            sample_valid = 1'b0;
            tr = sel ? int'(triggered3) : int'(triggered);
            st = sel ? int'(state3) : int'(state);
            if (i == trig_at - 1) checkOutput("no_early_trig", tr, 0);
            if (i == trig_at) begin
                checkOutput("trig_pulse", tr, 1);
                checkOutput("trig_state_capture", st, 2);
            end
            if (i == trig_at + 1) checkOutput("trig_pulse_ended", tr, 0);
            if (i == stop_at) run = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    initial begin
        int s, r;
        int cols2[7] = '{0, 1, 64, 127, 128, 300, 639};
        int cols3[4] = '{0, 1, 2, 639};

        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 8'd0;
        trig_level   = 8'd128;
        run          = 1'b1;
        h_counter    = 10'd700;
        v_counter    = 12'd10;
        repeat (2) step();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_disp_bank", disp_bank, 0);
        checkOutput("rst_display_valid", display_valid, 0);
        checkOutput("rst_triggered", triggered, 0);
        reset_n = 1'b1;
        step();
        checkOutput("arm_to_wait", state, 1);

        // Idle frames: graticule only
        frame();
        frame();
        checkOutput("idle_state", state, 1);
        checkOutput("idle_display_valid", display_valid, 0);
        applyStimulus(0, 0, 0, 4);
        applyStimulus(0, 64, 10, 4);
        applyStimulus(0, 10, 48, 4);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 700, 10, 0);

        // Ramp capture with a rising-edge trigger at 128
        do_reset();
        feed_ramp(768, 4, 128, -1, 0);
        checkOutput("ramp_done", state, 3);
        checkOutput("ramp_no_swap_yet", display_valid, 0);
        frame();
        checkOutput("ramp_swap_bank", disp_bank, 1);
        checkOutput("ramp_swap_valid", display_valid, 1);
        checkOutput("ramp_rearm", state, 0);
        foreach (cols2[k]) begin
            s = (128 + cols2[k]) % 256;
            r = 367 - s;
            applyStimulus(0, cols2[k], r, pix(cols2[k], r, 1, s));
            applyStimulus(0, cols2[k], r + 1, grid_pix(cols2[k], r + 1));
        end

        // Auto trigger after 8 frame boundaries on a flat input
        do_reset();
        repeat (7) frame();
        sample_valid = 1'b1;
        sample_data  = 8'd50;
        step();
        sample_valid = 1'b0;
        checkOutput("auto_not_before_8", state, 1);
        frame();
        for (int i = 0; i < 640; i++) begin
            sample_valid = 1'b1;
            sample_data  = 8'd50;
            step();
            sample_valid = 1'b0;
            if (i == 0) begin
                checkOutput("auto_trig_pulse", triggered, 1);
                checkOutput("auto_capture", state, 2);
            end
            step();
        end
        checkOutput("auto_done", state, 3);
        frame();
        checkOutput("auto_bank", disp_bank, 1);
        applyStimulus(0, 0, 317, 15);
        applyStimulus(0, 100, 317, 15);
        applyStimulus(0, 639, 317, 15);
        applyStimulus(0, 100, 316, grid_pix(100, 316));

        // Stop mode: run dropped mid-capture
        do_reset();
        feed_ramp(768, 2, 128, 400, 0);
        checkOutput("stop_done", state, 3);
        frame();
        checkOutput("stop_swap_bank", disp_bank, 1);
        checkOutput("stop_swap_valid", display_valid, 1);
        checkOutput("stop_hold", state, 3);
        for (int f = 0; f < 3; f++) begin
            frame();
            checkOutput("stop_hold_more", state, 3);
            checkOutput("stop_no_reswap", disp_bank, 1);
        end
        run = 1'b1;
        frame();
        checkOutput("stop_resume_arm", state, 0);
        checkOutput("stop_resume_no_swap", disp_bank, 1);
        step();

        // Reset in the middle of a capture at write address 300
        feed_ramp(428, 2, 128, -1, 0);
        checkOutput("mid_capture", state, 2);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_state", state, 0);
        checkOutput("async_rst_valid", display_valid, 0);
        checkOutput("async_rst_bank", disp_bank, 0);
        step();
        reset_n = 1'b1;
        step();
        applyStimulus(0, 5, 234, pix(5, 234, 0, 133));
        applyStimulus(0, 200, 295, pix(200, 295, 0, 72));
        applyStimulus(0, 64, 175, pix(64, 175, 0, 192));

        // Decimation by 3 on the second instance
        do_reset();
        feed_ramp(2047, 2, 129, -1, 1);
        checkOutput("dec3_done", state3, 3);
        frame();
        checkOutput("dec3_bank", disp_bank3, 1);
        checkOutput("dec3_valid", display_valid3, 1);
        foreach (cols3[k]) begin
            s = (129 + 3 * cols3[k]) % 256;
            r = 367 - s;
            applyStimulus(1, cols3[k], r, pix(cols3[k], r, 1, s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
